op_sequencer: RTL and testbench

Command queue and issue controller that sits directly upstream of the 512-bit vector processor. It buffers load/store/sum/product commands from the host side and replays them onto the processor's `operation`/`addr`/`data` port, one command at a time, for a fixed number of cycles per opcode. It drives the shared data bus for loads, releases it for all other opcodes, and captures the bus on the last cycle of a store.

---
 rtl/op_sequencer.sv | 160 ++++++++++++++++
 tb/tb_op_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// Command FIFO plus issue controller for the vector processor port.
// Each popped command is replayed for a fixed per-opcode cycle count; outputs lag the issue stage by one register.
module op_sequencer #(
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned LOAD_CYCLES  = 1,
  parameter int unsigned STORE_CYCLES = 1,
  parameter int unsigned MATH_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_data,
  input  logic                      halt,
  output logic [1:0]                operation,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_oe,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      busy,
  output logic                      op_done,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;

  typedef enum logic {
    S_IDLE,
    S_EXEC
  } state_t;

  state_t              state;
  logic [1:0]          fifo_op   [DEPTH];
  logic [ADDR_W-1:0]   fifo_addr [DEPTH];
  logic [DATA_W-1:0]   fifo_data [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  logic [1:0]          iss_op;
  logic [ADDR_W-1:0]   iss_addr;
  logic [DATA_W-1:0]   iss_data;
  logic [CNT_W-1:0]    cnt;

  logic                push;
  logic                pop;
  logic [1:0]          head_op;
  logic [CNT_W-1:0]    head_cnt;

  // Pop only from a registered, non-empty FIFO: either from idle or at the last cycle of a command.
  always_comb begin
    cmd_ready = (level != LVL_W'(DEPTH));
    push      = cmd_valid && cmd_ready;
    pop       = (level != '0) && !halt && ((state == S_IDLE) || (cnt == '0));
    head_op   = fifo_op[rd_ptr];
    case (head_op)
      OP_LOAD:  head_cnt = CNT_W'(LOAD_CYCLES - 1);
      OP_STORE: head_cnt = CNT_W'(STORE_CYCLES - 1);
      default:  head_cnt = CNT_W'(MATH_CYCLES - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      iss_op    <= OP_STORE;
      iss_addr  <= '0;
      iss_data  <= '0;
      cnt       <= '0;
      operation <= OP_STORE;
      addr      <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      busy      <= 1'b0;
      op_done   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (push) begin
        fifo_op[wr_ptr]   <= cmd_op;
        fifo_addr[wr_ptr] <= cmd_addr;
        fifo_data[wr_ptr] <= cmd_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end

      // Issue stage: pop into issue registers and count down the hold window.
      case (state)
        S_IDLE: begin
          if (pop) begin
            iss_op   <= head_op;
            iss_addr <= fifo_addr[rd_ptr];
            iss_data <= fifo_data[rd_ptr];
            cnt      <= head_cnt;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            if (pop) begin
              iss_op   <= head_op;
              iss_addr <= fifo_addr[rd_ptr];
              iss_data <= fifo_data[rd_ptr];
              cnt      <= head_cnt;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      // Processor port: registered image of the issue stage.
      if (state == S_EXEC) begin
        operation <= iss_op;
        addr      <= iss_addr;
        busy      <= 1'b1;
        op_done   <= (cnt == '0);
        data_oe   <= (iss_op == OP_LOAD);
        data_out  <= (iss_op == OP_LOAD) ? iss_data : '0;
      end else begin
        operation <= OP_STORE;
        addr      <= '0;
        busy      <= 1'b0;
        op_done   <= 1'b0;
        data_oe   <= 1'b0;
        data_out  <= '0;
      end

      // Capture the bus at the edge closing a store's last cycle.
      rd_valid <= busy && op_done && (operation == OP_STORE);
      if (busy && op_done && (operation == OP_STORE)) begin
        rd_data <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: stimulus queues expected port cycles, a negedge monitor checks them.
module tb_op_sequencer;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 9;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic          oe;
    logic [DW-1:0] dout;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          halt;
  logic [1:0]    operation;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic [DW-1:0] data_in;
  logic          busy;
  logic          op_done;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [3:0]    level;

  exp_t          exp_q[$];
  logic [DW-1:0] rd_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  op_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .halt(halt),
    .operation(operation), .addr(addr), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in),
    .busy(busy), .op_done(op_done), .rd_valid(rd_valid), .rd_data(rd_data),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int cycles_of(input logic [1:0] op);
    return (op == 2'b10 || op == 2'b11) ? 2 : 1;
  endfunction

  // Called at a negedge; offers one command across the next edge and records its expected port cycles.
  task automatic push_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = cycles_of(op);
    for (int i = 0; i < n; i++) begin
      e.op   = op;
      e.addr = a;
      e.oe   = (op == 2'b00);
      e.dout = (op == 2'b00) ? d : DW'(0);
      e.done = (i == n - 1);
      exp_q.push_back(e);
    end
    if (op == 2'b01) rd_q.push_back(DW'(16'h1234));
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(name, DW'(exp_q.size()), DW'(0));
  endtask

  // Monitor: every busy cycle must match the head of the expected queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b0 && busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_issue: got op %0h addr %0h, want no command", operation, addr);
      end else begin
        e = exp_q.pop_front();
        check("mon_operation", DW'(operation), DW'(e.op));
        check("mon_addr", DW'(addr), DW'(e.addr));
        check("mon_data_oe", DW'(data_oe), DW'(e.oe));
        check("mon_data_out", data_out, e.dout);
        check("mon_op_done", DW'(op_done), DW'(e.done));
      end
    end
    if (reset === 1'b0 && rd_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got rd_data %0h, want no capture", rd_data);
      end else begin
        check("mon_rd_data", rd_data, rd_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int streak;
    int k;
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_addr  = AW'(7);
    cmd_data  = {64{8'hFF}};
    halt      = 1'b0;
    data_in   = DW'(12'hBAD);

    // Reset with a command offered.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_operation", DW'(operation), DW'(2'b01));
    check("rst_addr", DW'(addr), DW'(0));
    check("rst_data_out", data_out, DW'(0));
    check("rst_data_oe", DW'(data_oe), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_op_done", DW'(op_done), DW'(0));
    check("rst_rd_valid", DW'(rd_valid), DW'(0));
    check("rst_rd_data", rd_data, DW'(0));
    check("rst_level", DW'(level), DW'(0));
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_level", DW'(level), DW'(0));
    check("post_rst_cmd_ready", DW'(cmd_ready), DW'(1));

    // Single load: visible two edges after acceptance, held one cycle.
    push_cmd(2'b00, AW'(5), {64{8'hA5}});
    check("load_level_pushed", DW'(level), DW'(1));
    check("load_busy_edge_n", DW'(busy), DW'(0));
    @(negedge clk);
    check("load_busy_edge_n1", DW'(busy), DW'(0));
    check("load_level_popped", DW'(level), DW'(0));
    @(negedge clk);
    check("load_busy_edge_n2", DW'(busy), DW'(1));
    check("load_op_done", DW'(op_done), DW'(1));
    @(negedge clk);
    check("load_then_idle", DW'(busy), DW'(0));
    check("load_idle_operation", DW'(operation), DW'(2'b01));

    // Store capture.
    data_in = DW'(16'h1234);
    push_cmd(2'b01, AW'(2), {64{8'h3C}});
    @(negedge clk);
    @(negedge clk);
    check("store_op_done", DW'(op_done), DW'(1));
    check("store_data_oe", DW'(data_oe), DW'(0));
    check("store_rd_valid_early", DW'(rd_valid), DW'(0));
    @(negedge clk);
    check("store_rd_valid", DW'(rd_valid), DW'(1));
    check("store_rd_data", rd_data, DW'(16'h1234));
    @(negedge clk);
    check("store_rd_valid_pulse", DW'(rd_valid), DW'(0));
    check("store_rd_q_empty", DW'(rd_q.size()), DW'(0));
    data_in = DW'(12'hBAD);

    // Fill under halt, reject a ninth, then drain back-to-back.
    halt = 1'b1;
    for (int i = 0; i < 8; i++) push_cmd(2'b10, AW'(10 + i), {64{8'h3C}});
    check("full_level", DW'(level), DW'(8));
    check("full_cmd_ready", DW'(cmd_ready), DW'(0));
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_addr  = AW'(99);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ninth_rejected", DW'(level), DW'(8));
    halt = 1'b0;
    @(negedge clk);
    check("ready_after_pop", DW'(cmd_ready), DW'(1));
    check("level_after_pop", DW'(level), DW'(7));
    streak = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && operation === 2'b10) streak++;
    end
    check("b2b_streak", DW'(streak), DW'(16));
    @(negedge clk);
    check("b2b_idle", DW'(busy), DW'(0));
    check("b2b_level", DW'(level), DW'(0));

    // Halt during the first product cycle.
    halt = 1'b1;
    push_cmd(2'b11, AW'(30), {64{8'h3C}});
    push_cmd(2'b00, AW'(31), {16{32'hDEADBEEF}});
    push_cmd(2'b00, AW'(32), {32{16'h0F0F}});
    halt = 1'b0;
    @(negedge clk);
    check("prod_not_yet", DW'(busy), DW'(0));
    @(negedge clk);
    check("prod_first_cycle", DW'(operation), DW'(2'b11));
    halt = 1'b1;
    @(negedge clk);
    check("prod_second_cycle", DW'(operation), DW'(2'b11));
    check("prod_done", DW'(op_done), DW'(1));
    @(negedge clk);
    check("halt_idle", DW'(busy), DW'(0));
    check("halt_level", DW'(level), DW'(2));
    streak = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) streak++;
    end
    check("halt_holds", DW'(streak), DW'(0));
    halt = 1'b0;
    wait_drain(20, "halt_drain");

    // Reset during the first product cycle with commands queued.
    halt = 1'b1;
    push_cmd(2'b11, AW'(40), {64{8'h3C}});
    push_cmd(2'b10, AW'(41), {64{8'h3C}});
    push_cmd(2'b00, AW'(42), {64{8'h77}});
    halt = 1'b0;
    k = 0;
    while (busy !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reached_exec", DW'(busy), DW'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", DW'(busy), DW'(0));
    check("rst_mid_level", DW'(level), DW'(0));
    check("rst_mid_operation", DW'(operation), DW'(2'b01));
    exp_q.delete();
    streak = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) streak++;
    end
    check("rst_mid_no_issue", DW'(streak), DW'(0));
    check("rst_mid_level_final", DW'(level), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
